// File: rtl/parallel_to_serial.sv
`default_nettype none
// ============================================================================
//  Module      : parallel_to_serial
//  Description : Byte serializer. Accepts an 8-bit word on a load/ready
//                handshake and sends it LSB-first as a generated serial
//                clock, a frame-start strobe and a data line, followed by a
//                fixed idle gap so the downstream receiver can finish its
//                valid cycle before the next frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module parallel_to_serial #(
    parameter int unsigned HALF_DIV = 4,   // sys_clk cycles per s_clk half period (1..255)
    parameter int unsigned GAP_BITS = 2    // idle bit periods after each frame (1..15)
) (
    input  logic       sys_clk,
    input  logic       i_rst,
    input  logic [7:0] D_in,
    input  logic       load,
    output logic       ready,
    output logic       done,
    output logic       s_clk,
    output logic       s_strobe,
    output logic       s_data
);

    // Last value of the half-period counter.
    localparam logic [7:0]  c_HALF_LAST = 8'(HALF_DIV - 1);
    // Last value of the gap counter: GAP_BITS bit periods of 2*HALF_DIV cycles.
    localparam logic [12:0] c_GAP_LAST  = 13'(GAP_BITS * 2 * HALF_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_half;
    logic [2:0]  r_bit;
    logic [12:0] r_gap;
    logic [7:0]  r_shreg;
    logic        r_ready;
    logic        r_done;
    logic        r_sclk;
    logic        r_strobe;

    state_t      w_state_next;
    logic [7:0]  w_half_next;
    logic [2:0]  w_bit_next;
    logic [12:0] w_gap_next;
    logic [7:0]  w_shreg_next;
    logic        w_ready_next;
    logic        w_done_next;
    logic        w_sclk_next;
    logic        w_strobe_next;

    // State and output registers; reset drops the link lines immediately.
    always_ff @(posedge sys_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_half   <= 8'd0;
            r_bit    <= 3'd0;
            r_gap    <= 13'd0;
            r_shreg  <= 8'd0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_sclk   <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_half   <= w_half_next;
            r_bit    <= w_bit_next;
            r_gap    <= w_gap_next;
            r_shreg  <= w_shreg_next;
            r_ready  <= w_ready_next;
            r_done   <= w_done_next;
            r_sclk   <= w_sclk_next;
            r_strobe <= w_strobe_next;
        end
    end

    // Next-state and next-output logic. The s_clk register doubles as the
    // phase flag: high for the first half of a bit period, low for the second.
    always_comb begin
        w_state_next  = r_state;
        w_half_next   = r_half;
        w_bit_next    = r_bit;
        w_gap_next    = r_gap;
        w_shreg_next  = r_shreg;
        w_ready_next  = r_ready;
        w_done_next   = 1'b0;
        w_sclk_next   = r_sclk;
        w_strobe_next = r_strobe;

        case (r_state)
            ST_IDLE: begin
                w_ready_next  = 1'b1;
                w_sclk_next   = 1'b0;
                w_strobe_next = 1'b0;
                if (load && r_ready) begin
                    // Bit 0 appears on the line in the very next cycle.
                    w_state_next  = ST_SHIFT;
                    w_shreg_next  = D_in;
                    w_half_next   = 8'd0;
                    w_bit_next    = 3'd0;
                    w_gap_next    = 13'd0;
                    w_ready_next  = 1'b0;
                    w_sclk_next   = 1'b1;
                    w_strobe_next = 1'b1;
                end
            end

            ST_SHIFT: begin
                if (r_half == c_HALF_LAST) begin
                    w_half_next = 8'd0;
                    if (r_sclk) begin
                        // Mid-bit: falling edge, data held stable for sampling.
                        w_sclk_next = 1'b0;
                    end else if (r_bit == 3'd7) begin
                        // Last bit done: line goes quiet; shift register is
                        // cleared so s_data reads 0 through gap and idle.
                        w_state_next  = ST_GAP;
                        w_bit_next    = 3'd0;
                        w_gap_next    = 13'd0;
                        w_shreg_next  = 8'd0;
                        w_sclk_next   = 1'b0;
                        w_strobe_next = 1'b0;
                    end else begin
                        // Bit boundary: next bit rides the rising edge.
                        w_bit_next    = r_bit + 3'd1;
                        w_shreg_next  = {1'b0, r_shreg[7:1]};
                        w_sclk_next   = 1'b1;
                        w_strobe_next = 1'b0;
                    end
                end else begin
                    w_half_next = r_half + 8'd1;
                end
            end

            ST_GAP: begin
                if (r_gap == c_GAP_LAST) begin
                    w_state_next = ST_IDLE;
                    w_gap_next   = 13'd0;
                    w_ready_next = 1'b1;
                    w_done_next  = 1'b1;
                end else begin
                    w_gap_next = r_gap + 13'd1;
                end
            end

            default: begin
                w_state_next  = ST_IDLE;
                w_ready_next  = 1'b1;
                w_sclk_next   = 1'b0;
                w_strobe_next = 1'b0;
                w_shreg_next  = 8'd0;
            end
        endcase
    end

    assign ready    = r_ready;
    assign done     = r_done;
    assign s_clk    = r_sclk;
    assign s_strobe = r_strobe;
    assign s_data   = r_shreg[0];

endmodule
`default_nettype wire

// File: tb/tb_parallel_to_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parallel_to_serial
//  Description : Self-checking bench for parallel_to_serial. Two instances
//                (HALF_DIV=4 and HALF_DIV=1) each feed a behavioural receiver
//                that samples s_data at s_clk falling edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parallel_to_serial;

    logic       sys_clk = 1'b0;
    logic       i_rst   = 1'b0;
    logic [1:0] load_a  = 2'b00;
    logic [7:0] d_a [2];
    logic [1:0] ready_a, done_a, sclk_a, strobe_a, sdata_a;

    int ecount = 0;
    int pass_cnt = 0;
    int total_cnt = 0;

    // Receiver / monitor state, written only by the monitor process.
    logic [7:0] rx_log   [2][64];
    int         rx_n     [2] = '{0, 0};
    int         done_log [2][64];
    int         done_n   [2] = '{0, 0};
    int         srise_log[2][64];
    int         srise_n  [2] = '{0, 0};
    int         sfall_log[2][64];
    int         sfall_n  [2] = '{0, 0};
    int         falls    [2] = '{0, 0};
    int         nb       [2] = '{0, 0};
    logic [7:0] sh       [2];
    logic       prev_sclk[2] = '{1'b0, 1'b0};
    logic       prev_stb [2] = '{1'b0, 1'b0};

    parallel_to_serial #(.HALF_DIV(4), .GAP_BITS(2)) dut0 (
        .sys_clk (sys_clk),
        .i_rst   (i_rst),
        .D_in    (d_a[0]),
        .load    (load_a[0]),
        .ready   (ready_a[0]),
        .done    (done_a[0]),
        .s_clk   (sclk_a[0]),
        .s_strobe(strobe_a[0]),
        .s_data  (sdata_a[0])
    );

    parallel_to_serial #(.HALF_DIV(1), .GAP_BITS(2)) dut1 (
        .sys_clk (sys_clk),
        .i_rst   (i_rst),
        .D_in    (d_a[1]),
        .load    (load_a[1]),
        .ready   (ready_a[1]),
        .done    (done_a[1]),
        .s_clk   (sclk_a[1]),
        .s_strobe(strobe_a[1]),
        .s_data  (sdata_a[1])
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) ecount <= ecount + 1;

    // Mid-cycle monitor: the interval after edge number N is cycle N.
    always @(negedge sys_clk) begin
        for (int i = 0; i < 2; i++) begin
            if (prev_sclk[i] === 1'b1 && sclk_a[i] === 1'b0) begin
                falls[i]++;
                if (strobe_a[i]) nb[i] = 0;
                sh[i] = {sdata_a[i], sh[i][7:1]};
                nb[i]++;
                if (nb[i] == 8) begin
                    if (rx_n[i] < 64) rx_log[i][rx_n[i]] = sh[i];
                    rx_n[i]++;
                    nb[i] = 0;
                end
            end
            if (strobe_a[i] === 1'b1 && prev_stb[i] !== 1'b1) begin
                if (srise_n[i] < 64) srise_log[i][srise_n[i]] = ecount;
                srise_n[i]++;
            end
            if (strobe_a[i] === 1'b0 && prev_stb[i] === 1'b1) begin
                if (sfall_n[i] < 64) sfall_log[i][sfall_n[i]] = ecount - 1;
                sfall_n[i]++;
            end
            if (done_a[i] === 1'b1) begin
                if (done_n[i] < 64) done_log[i][done_n[i]] = ecount;
                done_n[i]++;
            end
            prev_sclk[i] = sclk_a[i];
            prev_stb[i]  = strobe_a[i];
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Pulse load for one edge; T is the spec's accept-edge reference.
    task automatic send(input int inst, input logic [7:0] d, output int t);
        @(negedge sys_clk);
        load_a[inst] = 1'b1;
        d_a[inst]    = d;
        @(posedge sys_clk);
        #1;
        t = ecount - 1;
        chk("ready_low_after_accept", int'(ready_a[inst]), 0);
        @(negedge sys_clk);
        load_a[inst] = 1'b0;
    endtask

    task automatic wait_done(input int inst, input int base, input int budget);
        int n = 0;
        while (done_n[inst] <= base && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        #1;
        chk("done_seen_in_budget", int'(done_n[inst] > base), 1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic [7:0] exp_byte;
        int         exp_done_off;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int t, rb, db, sb, fb;

        vecs[0] = '{0, 8'h00, 8'h00, 81};
        vecs[1] = '{0, 8'hFF, 8'hFF, 81};
        vecs[2] = '{0, 8'h5A, 8'h5A, 81};
        vecs[3] = '{0, 8'hC3, 8'hC3, 81};
        vecs[4] = '{1, 8'h00, 8'h00, 21};
        vecs[5] = '{1, 8'hFF, 8'hFF, 21};
        vecs[6] = '{1, 8'h5A, 8'h5A, 21};
        vecs[7] = '{1, 8'hC3, 8'hC3, 21};
        d_a[0] = 8'h00;
        d_a[1] = 8'h00;

        // Reset asserted mid-cycle: outputs must settle without a clock edge.
        idle_cycles(2);
        #2 i_rst = 1'b1;
        #1;
        chk("rst_ready", int'(ready_a[0]), 1);
        chk("rst_done", int'(done_a[0]), 0);
        chk("rst_sclk", int'(sclk_a[0]), 0);
        chk("rst_strobe", int'(strobe_a[0]), 0);
        chk("rst_sdata", int'(sdata_a[0]), 0);
        chk("rst_ready_h1", int'(ready_a[1]), 1);
        idle_cycles(2);
        i_rst = 1'b0;
        idle_cycles(10);
        chk("idle_outputs", int'({ready_a[0], done_a[0], sclk_a[0], strobe_a[0], sdata_a[0]}), 5'b10000);

        // Single frame A5.
        rb = rx_n[0]; db = done_n[0]; sb = srise_n[0]; fb = falls[0];
        send(0, 8'hA5, t);
        wait_done(0, db, 200);
        chk("a5_byte", int'(rx_log[0][rb]), 8'hA5);
        chk("a5_falls", falls[0] - fb, 8);
        chk("a5_strobe_first", srise_log[0][sb], t + 1);
        chk("a5_strobe_last", sfall_log[0][sb], t + 8);
        chk("a5_done_cycle", done_log[0][db], t + 81);
        chk("a5_ready_at_done", int'(ready_a[0]), 1);

        // Load while busy is ignored.
        rb = rx_n[0]; db = done_n[0]; sb = srise_n[0];
        send(0, 8'h3C, t);
        while (ecount < t + 19) @(negedge sys_clk);
        load_a[0] = 1'b1;
        d_a[0]    = 8'hFF;
        @(negedge sys_clk);
        load_a[0] = 1'b0;
        wait_done(0, db, 200);
        chk("busy_byte", int'(rx_log[0][rb]), 8'h3C);
        idle_cycles(100);
        chk("busy_one_frame", srise_n[0] - sb, 1);
        chk("busy_one_done", done_n[0] - db, 1);

        // Back-to-back with load held high.
        rb = rx_n[0]; db = done_n[0]; sb = srise_n[0];
        @(negedge sys_clk);
        load_a[0] = 1'b1;
        d_a[0]    = 8'h01;
        @(posedge sys_clk);
        #1;
        t = ecount - 1;
        d_a[0] = 8'h80;
        for (int n = 0; n < 300 && srise_n[0] < sb + 2; n++) @(negedge sys_clk);
        load_a[0] = 1'b0;
        chk("b2b_second_start_seen", int'(srise_n[0] >= sb + 2), 1);
        wait_done(0, db + 1, 200);
        chk("b2b_second_strobe", srise_log[0][sb + 1], t + 82);
        chk("b2b_byte0", int'(rx_log[0][rb]), 8'h01);
        chk("b2b_byte1", int'(rx_log[0][rb + 1]), 8'h80);
        chk("b2b_done0", done_log[0][db], t + 81);
        chk("b2b_done1", done_log[0][db + 1], t + 162);

        // Reset during bit 3 truncates the frame.
        rb = rx_n[0]; db = done_n[0];
        send(0, 8'hFF, t);
        while (ecount < t + 27) @(negedge sys_clk);
        chk("mid_sclk_before_rst", int'(sclk_a[0]), 1);
        #2 i_rst = 1'b1;
        #1;
        chk("mid_rst_sclk", int'(sclk_a[0]), 0);
        chk("mid_rst_strobe", int'(strobe_a[0]), 0);
        chk("mid_rst_sdata", int'(sdata_a[0]), 0);
        chk("mid_rst_ready", int'(ready_a[0]), 1);
        @(negedge sys_clk);
        i_rst = 1'b0;
        idle_cycles(100);
        chk("mid_rst_no_done", done_n[0] - db, 0);
        chk("mid_rst_no_byte", rx_n[0] - rb, 0);
        rb = rx_n[0]; db = done_n[0];
        send(0, 8'h0F, t);
        wait_done(0, db, 200);
        chk("after_rst_byte", int'(rx_log[0][rb]), 8'h0F);

        // Loopback table across both divider settings.
        for (int v = 0; v < 8; v++) begin
            int k;
            k  = vecs[v].inst;
            rb = rx_n[k]; db = done_n[k]; fb = falls[k];
            send(k, vecs[v].data, t);
            wait_done(k, db, 200);
            chk($sformatf("loop%0d_byte", v), int'(rx_log[k][rb]), int'(vecs[v].exp_byte));
            chk($sformatf("loop%0d_valid", v), rx_n[k] - rb, 1);
            chk($sformatf("loop%0d_falls", v), falls[k] - fb, 8);
            chk($sformatf("loop%0d_done", v), done_log[k][db], t + vecs[v].exp_done_off);
            idle_cycles(3);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
